// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Dual-port word memory facing the core's instruction and data ports.
// Both ports are read-first: every enabled access returns the word as it
// was before any write in that same cycle. The data port also exposes a
// free-running cycle counter at CNT_ADDR. Any access outside the array
// (or outside the counter, on the data port) sets a sticky error flag and
// captures the first offending address.
module cpu_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LATENCY  = 1,
  parameter logic [31:0] CNT_ADDR    = 32'h3FFF_FFFF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  input  logic        inst_en,
  input  logic [3:0]  inst_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  input  logic        data_en,
  input  logic [3:0]  data_we,
  output logic        err_oob,
  output logic [31:0] err_addr
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  // Array contents are never reset; they start as zero at elaboration.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic          inst_hit;
  logic          data_hit;
  logic          data_cnt;
  logic          inst_oob;
  logic          data_oob;
  logic          inst_wr;
  logic          data_wr;
  logic          cnt_clr;
  logic [AW-1:0] inst_idx;
  logic [AW-1:0] data_idx;
  logic [31:0]   inst_word;
  logic [31:0]   data_word;
  logic [31:0]   cnt;
  logic          inst_v1;
  logic          data_v1;
  logic [31:0]   inst_d1;
  logic [31:0]   data_d1;

  // Range decode and pre-write read word for each port.
  always_comb begin
    inst_hit  = inst_addr < DEPTH_LIM;
    data_cnt  = data_addr == CNT_ADDR;
    data_hit  = (data_addr < DEPTH_LIM) && !data_cnt;
    inst_idx  = inst_addr[AW-1:0];
    data_idx  = data_addr[AW-1:0];
    inst_oob  = inst_en && !inst_hit;
    data_oob  = data_en && !data_hit && !data_cnt;
    inst_wr   = inst_en && inst_hit && (inst_we != 4'b0000);
    data_wr   = data_en && data_hit && (data_we != 4'b0000);
    cnt_clr   = data_en && data_cnt && (data_we != 4'b0000);
    inst_word = inst_hit ? mem[inst_idx] : 32'h0;
    data_word = data_cnt ? cnt : (data_hit ? mem[data_idx] : 32'h0);
  end

  // Byte-lane writes; the data-port assignment comes last so it wins a
  // lane that both ports enable on the same word.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      for (int b = 0; b < 4; b++) begin
        if (inst_wr && inst_we[b]) mem[inst_idx][8*b +: 8] <= inst_wdata[8*b +: 8];
        if (data_wr && data_we[b]) mem[data_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  // Cycle counter. A clear makes the write cycle count as zero, so the
  // register is loaded with 1 and a read in the following cycle sees 1.
  always_ff @(posedge aclk) begin
    if (!aresetn)     cnt <= 32'h0;
    else if (cnt_clr) cnt <= 32'h1;
    else              cnt <= cnt + 32'h1;
  end

  // Sticky out-of-range capture; the data port wins a same-cycle tie.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_oob  <= 1'b0;
      err_addr <= 32'h0;
    end else if (!err_oob && (inst_oob || data_oob)) begin
      err_oob  <= 1'b1;
      err_addr <= data_oob ? data_addr : inst_addr;
    end
  end

  // Read pipeline: one or two register stages; rdata holds between reads.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      inst_v1    <= 1'b0;
      data_v1    <= 1'b0;
      inst_d1    <= 32'h0;
      data_d1    <= 32'h0;
      inst_rdata <= 32'h0;
      data_rdata <= 32'h0;
    end else begin
      inst_v1 <= inst_en;
      data_v1 <= data_en;
      if (inst_en) inst_d1 <= inst_word;
      if (data_en) data_d1 <= data_word;
      if (RD_LATENCY == 1) begin
        if (inst_en) inst_rdata <= inst_word;
        if (data_en) data_rdata <= data_word;
      end else begin
        if (inst_v1) inst_rdata <= inst_d1;
        if (data_v1) data_rdata <= data_d1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: one instance at read latency 1 and one at
// latency 2 share every input; a scoreboard holds expected read data per
// instance and is drained when each instance's data is due.
module tb_cpu_mem_responder;

  localparam logic [31:0] CNT_A = 32'h3FFF_FFFF;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_en, data_en;
  logic [3:0]  inst_we, data_we;
  logic [31:0] l1_inst_rdata, l1_data_rdata, l1_err_addr;
  logic [31:0] l2_inst_rdata, l2_data_rdata, l2_err_addr;
  logic        l1_err_oob, l2_err_oob;

  cpu_mem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(1), .CNT_ADDR(CNT_A)) dut_l1 (
    .aclk(aclk), .aresetn(aresetn),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(l1_inst_rdata),
    .inst_en(inst_en), .inst_we(inst_we),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(l1_data_rdata),
    .data_en(data_en), .data_we(data_we),
    .err_oob(l1_err_oob), .err_addr(l1_err_addr)
  );

  cpu_mem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(2), .CNT_ADDR(CNT_A)) dut_l2 (
    .aclk(aclk), .aresetn(aresetn),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(l2_inst_rdata),
    .inst_en(inst_en), .inst_we(inst_we),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(l2_data_rdata),
    .data_en(data_en), .data_we(data_we),
    .err_oob(l2_err_oob), .err_addr(l2_err_addr)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        ie;  logic [3:0] iwe; logic [31:0] ia; logic [31:0] iwd;
    logic        ci;  logic [31:0] ei;
    logic        de;  logic [3:0] dwe; logic [31:0] da; logic [31:0] dwd;
    logic        cd;  logic dcnt; logic [31:0] ed;
  } vec_t;

  typedef struct {
    int          due;
    logic        port;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t  q1[$];
  sb_t  q2[$];
  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   base  = 0;   // edge number at which the counter reads 0

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input string n,
      input logic ie, input logic [3:0] iwe, input logic [31:0] ia, input logic [31:0] iwd,
      input logic ci, input logic [31:0] ei,
      input logic de, input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dwd,
      input logic cd, input logic dcnt, input logic [31:0] ed);
    vec_t v;
    v.name = n; v.ie = ie; v.iwe = iwe; v.ia = ia; v.iwd = iwd; v.ci = ci; v.ei = ei;
    v.de = de; v.dwe = dwe; v.da = da; v.dwd = dwd; v.cd = cd; v.dcnt = dcnt; v.ed = ed;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk("idle", 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input string nm, input logic port, input logic [31:0] exp);
    sb_t e;
    e.port = port; e.exp = exp; e.name = nm;
    e.due = cyc + 1; q1.push_back(e);
    e.due = cyc + 2; q2.push_back(e);
  endtask

  // Drive one cycle of stimulus; the access edge is the next rising edge.
  task automatic step(input vec_t v);
    logic [31:0] dexp;
    inst_en = v.ie; inst_we = v.iwe; inst_addr = v.ia; inst_wdata = v.iwd;
    data_en = v.de; data_we = v.dwe; data_addr = v.da; data_wdata = v.dwd;
    dexp = v.dcnt ? 32'(cyc + 1 - base) : v.ed;
    if (v.ie && v.ci) push({v.name, "_inst"}, 1'b0, v.ei);
    if (v.de && v.cd) push({v.name, "_data"}, 1'b1, dexp);
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_err(input string nm, input logic eo, input logic [31:0] ea);
    check({nm, "_oob_l1"}, 32'(l1_err_oob), 32'(eo));
    check({nm, "_addr_l1"}, l1_err_addr, ea);
    check({nm, "_oob_l2"}, 32'(l2_err_oob), 32'(eo));
    check({nm, "_addr_l2"}, l2_err_addr, ea);
  endtask

  sb_t e1, e2;
  always @(negedge aclk) begin
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      e1 = q1.pop_front();
      check({e1.name, "_l1"}, e1.port ? l1_data_rdata : l1_inst_rdata, e1.exp);
    end
    while (q2.size() > 0 && q2[0].due <= cyc) begin
      e2 = q2.pop_front();
      check({e2.name, "_l2"}, e2.port ? l2_data_rdata : l2_inst_rdata, e2.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c0;
    int w;

    aresetn = 1'b0;
    inst_en = 0; inst_we = 0; inst_addr = 0; inst_wdata = 0;
    data_en = 0; data_we = 0; data_addr = 0; data_wdata = 0;
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    check("rst_inst_rdata_l1", l1_inst_rdata, 32'h0);
    check("rst_data_rdata_l2", l2_data_rdata, 32'h0);
    chk_err("rst_err", 1'b0, 32'h0);
    aresetn = 1'b1;
    base = cyc + 1;

    //         name          ie iwe   ia    iwd           ci ei            de dwe   da    dwd           cd cnt ed
    vq.push_back(mk("wr5",       0, 4'h0, 0,    0,            0, 0,            1, 4'hF, 5,    32'hDEADBEEF, 1, 0, 32'h0));
    vq.push_back(mk("rd5",       1, 4'h0, 5,    0,            1, 32'hDEADBEEF, 0, 4'h0, 0,    0,            0, 0, 32'h0));
    vq.push_back(mk("wr7",       0, 4'h0, 0,    0,            0, 0,            1, 4'hF, 7,    32'h11223344, 1, 0, 32'h0));
    vq.push_back(mk("wr7_lanes", 0, 4'h0, 0,    0,            0, 0,            1, 4'h5, 7,    32'hAABBCCDD, 1, 0, 32'h11223344));
    vq.push_back(mk("rd7_rd5",   1, 4'h0, 7,    0,            1, 32'h11BB33DD, 1, 4'h0, 5,    0,            1, 0, 32'hDEADBEEF));
    vq.push_back(mk("coll3",     1, 4'hF, 3,    32'hFFFFFFFF, 1, 32'h0,        1, 4'h3, 3,    32'h00000000, 1, 0, 32'h0));
    vq.push_back(mk("rd3",       1, 4'h0, 3,    0,            1, 32'hFFFF0000, 1, 4'h0, 3,    0,            1, 0, 32'hFFFF0000));
    vq.push_back(mk("xport_rf",  1, 4'hF, 3,    32'h12345678, 1, 32'hFFFF0000, 1, 4'h0, 3,    0,            1, 0, 32'hFFFF0000));
    vq.push_back(mk("rd3_top",   1, 4'h0, 1023, 0,            1, 32'h0,        1, 4'h0, 3,    0,            1, 0, 32'h12345678));
    vq.push_back(mk("wrtop",     1, 4'h0, 1023, 0,            1, 32'h0,        1, 4'hF, 1023, 32'hCAFEF00D, 1, 0, 32'h0));
    vq.push_back(mk("rdtop",     1, 4'h0, 1023, 0,            1, 32'hCAFEF00D, 1, 4'h0, 0,    0,            1, 0, 32'h0));
    vq.push_back(mk("coll4",     1, 4'hC, 4,    32'hA1A2A3A4, 1, 32'h0,        1, 4'h6, 4,    32'hB1B2B3B4, 1, 0, 32'h0));
    vq.push_back(mk("rd4",       1, 4'h0, 4,    0,            1, 32'hA1B2B300, 0, 4'h0, 0,    0,            0, 0, 32'h0));
    vq.push_back(mk("oob_wr",    0, 4'h0, 0,    0,            0, 0,            1, 4'hF, 1024, 32'h55555555, 1, 0, 32'h0));
    vq.push_back(mk("oob_rd",    1, 4'h0, 2000, 0,            1, 32'h0,        1, 4'h0, 0,    0,            1, 0, 32'h0));

    for (int i = 0; i < vq.size(); i++) step(vq[i]);
    step(idle());
    step(idle());
    chk_err("oob_first", 1'b1, 32'd1024);

    // Counter: two reads ten cycles apart, then hold while idle.
    c0 = 32'(cyc + 1 - base);
    step(mk("cnt_a", 0, 4'h0, 0, 0, 0, 0, 1, 4'h0, CNT_A, 0, 1, 1, 0));
    repeat (3) step(idle());
    check("hold_l1", l1_data_rdata, c0);
    check("hold_l2", l2_data_rdata, c0);
    repeat (6) step(idle());
    check("cnt_gap_model", 32'(cyc + 1 - base), c0 + 32'd10);
    step(mk("cnt_b", 0, 4'h0, 0, 0, 0, 0, 1, 4'h0, CNT_A, 0, 1, 1, 0));
    w = cyc + 1;
    step(mk("cnt_clr", 0, 4'h0, 0, 0, 0, 0, 1, 4'h1, CNT_A, 32'hFFFFFFFF, 1, 1, 0));
    base = w;
    step(mk("cnt_after_clr", 0, 4'h0, 0, 0, 0, 0, 1, 4'h0, CNT_A, 0, 1, 0, 32'h1));
    step(idle());
    step(idle());

    // Reset arriving while a latency-2 read of addr 5 is in flight.
    step(mk("rd5_inflight", 0, 4'h0, 0, 0, 0, 0, 1, 4'h0, 5, 0, 0, 0, 0));
    aresetn = 1'b0;
    data_en = 1; data_we = 4'hF; data_addr = 9; data_wdata = 32'h77777777;
    inst_en = 1; inst_we = 4'h0; inst_addr = 3000;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk);
      #1;
      @(negedge aclk);
      check("midrst_data_l2", l2_data_rdata, 32'h0);
      check("midrst_data_l1", l1_data_rdata, 32'h0);
    end
    chk_err("midrst_err", 1'b0, 32'h0);
    inst_en = 0; data_en = 0; data_we = 0;
    aresetn = 1'b1;
    base = cyc + 1;
    step(mk("post_rst", 1, 4'h0, 9, 0, 1, 32'h0, 1, 4'h0, CNT_A, 0, 1, 1, 0));
    step(idle());
    chk_err("post_rst_err", 1'b0, 32'h0);

    // Counter address is out of range on the instruction port.
    step(mk("inst_cnt", 1, 4'h0, CNT_A, 0, 1, 32'h0, 0, 4'h0, 0, 0, 0, 0, 0));
    step(idle());
    chk_err("inst_cnt_err", 1'b1, CNT_A);
    step(idle());

    // Both ports out of range in one cycle: the data address is kept.
    aresetn = 1'b0;
    repeat (2) step(idle());
    aresetn = 1'b1;
    base = cyc + 1;
    step(mk("dual_oob", 1, 4'h0, 5000, 0, 1, 32'h0, 1, 4'h0, 6000, 0, 1, 0, 32'h0));
    step(idle());
    chk_err("dual_oob_err", 1'b1, 32'd6000);
    step(idle());
    step(idle());

    check("sb_left_l1", 32'(q1.size()), 32'h0);
    check("sb_left_l2", 32'(q2.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Dual-port synchronous memory responder that serves the CPU core's instruction port and data port. It sits directly opposite the core's memory interface: it accepts the core's address, write data, enable and byte write-enables on each port and returns read data after a fixed pipeline latency. It also implements a memory-mapped free-running cycle counter on the data port, and flags out-of-range accesses with a sticky error indication.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, 16..65536.
- RD_LATENCY, 1: read latency in cycles; legal values are 1 or 2.
- CNT_ADDR, 32'h3FFF_FFFF: word address of the cycle-counter register. Data port only.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; synchronous, active-low.
- inst_addr  in  32  instruction-port word address; bit 0 selects word 0/1, not byte.
- inst_wdata  in  32  instruction-port write data.
- inst_rdata  out  32  instruction-port read data.
- inst_en  in  1  instruction-port access enable.
- inst_we  in  4  instruction-port byte write enables; bit n writes byte lane n, i.e. bits [8n+7:8n].
- data_addr  in  32  data-port word address.
- data_wdata  in  32  data-port write data.
- data_rdata  out  32  data-port read data.
- data_en  in  1  data-port access enable.
- data_we  in  4  data-port byte write enables.
- err_oob  out  1  sticky out-of-range flag.
- err_addr  out  32  address of the first out-of-range access since reset.

## Operation
- **Access definition.** An access occurs on a port in a cycle where en=1.
  - we=4'b0000: read.
  - we nonzero: write of the selected lanes only. Unselected lanes keep their old value.
  - en=0: no access. we is ignored.
- **In range.** Addresses 0..DEPTH_WORDS-1. The word is indexed by addr[log2(DEPTH_WORDS)-1:0] after the range check passes.
- **Out of range.** Any other address except CNT_ADDR on the data port.
  - Writes are dropped.
  - Reads return 32'h0.
  - If err_oob=0: err_oob is set to 1 and err_addr captures the address. Later out-of-range accesses do not change err_addr.
  - If both ports are out of range in the same cycle, the data-port address is captured.
- **Read-first behaviour.**
  - A read that also writes on the same port returns the pre-write word.
  - A read of the address being written by the other port in the same cycle also returns the pre-write word.
- **Write collision.** Both ports write the same word in the same cycle. Per byte lane, data-port data wins where both enables are set. Lanes enabled on only one port take that port's data.
- **Cycle counter.**
  - 32-bit, increments every cycle out of reset and wraps at 32'hFFFF_FFFF to 0.
  - A data-port read at CNT_ADDR returns the counter value sampled in the access cycle.
  - A data-port write at CNT_ADDR with any nonzero we clears it to 0. The next cycle the counter reads 1.
  - CNT_ADDR on the instruction port is treated as out of range.
- **Array contents.** Not reset. Zero-initialised at elaboration.

## Timing
- **Read latency.**
  - RD_LATENCY=1: rdata is valid on the first rising edge after the access edge.
  - RD_LATENCY=2: rdata is valid on the second rising edge; back-to-back reads are fully pipelined, one per cycle per port.
- **rdata hold.** rdata holds its last value when no read completes. It is not cleared by en=0.
- **Write visibility.** A write becomes visible to a read issued on the following cycle on either port.
- **Reset values.** inst_rdata=0, data_rdata=0, err_oob=0, err_addr=0, counter=0.
- **Reset mid-operation.**
  - Reads in flight in the latency pipeline are discarded; rdata=0 after the reset edge.
  - Accesses presented while aresetn=0 are ignored: no array write, no error capture.
- **First access after reset.** The first access is accepted on the first edge with aresetn=1.

## Test plan
- **Pipelined write/read, RD_LATENCY=1.**
  - Data-port write 32'hDEADBEEF at addr 5, we=4'hF.
  - Next cycle, instruction-port read of addr 5 → inst_rdata=32'hDEADBEEF one cycle later.
  - Repeat with RD_LATENCY=2 → value appears two cycles later.
- **Byte lanes.**
  - Write 32'h11223344 to addr 7.
  - Then write 32'hAABBCCDD with we=4'b0101.
  - Read → 32'h11BB33DD.
- **Collision.**
  - Same cycle, addr 3: inst port writes 32'hFFFFFFFF with we=4'hF; data port writes 32'h00000000 with we=4'b0011.
  - Read → 32'hFFFF0000.
  - Same-cycle read of addr 3 on the data port returns the previous contents.
- **Out of range.** DEPTH_WORDS=1024.
  - Data write to addr 1024 → array unchanged, err_oob=1, err_addr=1024.
  - Later inst read of addr 2000 → inst_rdata=0, err_addr stays 1024.
- **Counter.**
  - Read CNT_ADDR at cycle N, then again 10 cycles later → difference is 10.
  - Write CNT_ADDR, then read on the next cycle → 1.
- **Reset mid-read.**
  - Issue a read of addr 5 (holding 32'hDEADBEEF) with RD_LATENCY=2.
  - Assert aresetn=0 on the following edge → data_rdata=0, never 32'hDEADBEEF.
  - err_oob=0, counter restarts at 0.
